// File: rtl/hdlc_rx_reader.sv
// Host-side HDLC receive reader: polls Rx_SC/Rx_Len, drains Rx_Buff and streams the payload.
// Build option: define HDLC_RX_READER_FCS_EN to switch receiver FCS checking on after reset.
module hdlc_rx_reader #(
    parameter int unsigned MAX_LEN = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx_Ready,
    output logic [2:0] Address,
    output logic       ReadEnable,
    output logic       WriteEnable,
    output logic [7:0] WrData,
    input  logic [7:0] RdData,
    output logic [7:0] M_Data,
    output logic       M_Valid,
    input  logic       M_Ready,
    output logic       M_Sof,
    output logic       M_Eof,
    output logic       Frm_Done,
    output logic [3:0] Frm_Err,
    input  logic       Drop_Req
);

    localparam logic [2:0] ADDR_SC   = 3'd2;
    localparam logic [2:0] ADDR_BUFF = 3'd3;
    localparam logic [2:0] ADDR_LEN  = 3'd4;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

`ifdef HDLC_RX_READER_FCS_EN
    localparam logic [7:0] DROP_CMD  = 8'h22;
    localparam logic [7:0] INIT_CMD  = 8'h20;
`else
    localparam logic [7:0] DROP_CMD  = 8'h02;
`endif

    typedef enum logic [3:0] {
        IDLE,
        RD_SC,
        W_SC,
        RD_LEN,
        W_LEN,
        RD_BYTE,
        W_BYTE,
        HOLD,
        DROP,
        DONE,
        WAIT_CLR
`ifdef HDLC_RX_READER_FCS_EN
        , INIT
`endif
    } state_t;

`ifdef HDLC_RX_READER_FCS_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t     state_reg, state_next;
    logic [2:0] addr_reg, addr_next;
    logic       rd_en_reg, rd_en_next;
    logic       wr_en_reg, wr_en_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic [7:0] m_data_reg, m_data_next;
    logic       m_valid_reg, m_valid_next;
    logic       m_sof_reg, m_sof_next;
    logic       m_eof_reg, m_eof_next;
    logic       frm_done_reg, frm_done_next;
    logic [3:0] frm_err_reg, frm_err_next;
    logic [3:0] err_reg, err_next;
    logic [6:0] len_reg, len_next;
    logic [6:0] cnt_reg, cnt_next;
    logic       host_drop;
    logic       len_bad;
    logic       enter_drop;

    // Every output is registered: the bus strobe seen in a state was decided on entry to it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg    <= RESET_STATE;
            addr_reg     <= 3'd0;
            rd_en_reg    <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= 8'd0;
            m_data_reg   <= 8'd0;
            m_valid_reg  <= 1'b0;
            m_sof_reg    <= 1'b0;
            m_eof_reg    <= 1'b0;
            frm_done_reg <= 1'b0;
            frm_err_reg  <= 4'd0;
            err_reg      <= 4'd0;
            len_reg      <= 7'd0;
            cnt_reg      <= 7'd0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            rd_en_reg    <= rd_en_next;
            wr_en_reg    <= wr_en_next;
            wr_data_reg  <= wr_data_next;
            m_data_reg   <= m_data_next;
            m_valid_reg  <= m_valid_next;
            m_sof_reg    <= m_sof_next;
            m_eof_reg    <= m_eof_next;
            frm_done_reg <= frm_done_next;
            frm_err_reg  <= frm_err_next;
            err_reg      <= err_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = 3'd0;
        rd_en_next    = 1'b0;
        wr_en_next    = 1'b0;
        wr_data_next  = 8'd0;
        m_data_next   = m_data_reg;
        m_valid_next  = m_valid_reg;
        m_sof_next    = m_sof_reg;
        m_eof_next    = m_eof_reg;
        frm_done_next = 1'b0;
        frm_err_next  = 4'd0;
        err_next      = err_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        enter_drop    = 1'b0;
        host_drop     = Drop_Req &&
                        (state_reg inside {RD_LEN, W_LEN, RD_BYTE, W_BYTE, HOLD});
        len_bad       = (RdData == 8'd0) || (RdData > MAX_LEN_B);

        case (state_reg)
`ifdef HDLC_RX_READER_FCS_EN
            INIT: begin
                wr_en_next   = 1'b1;
                addr_next    = ADDR_SC;
                wr_data_next = INIT_CMD;
                state_next   = IDLE;
            end
`endif
            IDLE: begin
                if (Rx_Ready) begin
                    rd_en_next = 1'b1;
                    addr_next  = ADDR_SC;
                    state_next = RD_SC;
                end
            end
            RD_SC: state_next = W_SC;
            W_SC: begin
                err_next   = {1'b0, RdData[4:2]};
                rd_en_next = 1'b1;
                addr_next  = ADDR_LEN;
                state_next = RD_LEN;
            end
            RD_LEN: state_next = W_LEN;
            W_LEN: begin
                if (len_bad || (err_reg[2:0] != 3'd0)) begin
                    err_next[3] = len_bad;
                    enter_drop  = 1'b1;
                end else begin
                    len_next   = RdData[6:0];
                    cnt_next   = 7'd0;
                    rd_en_next = 1'b1;
                    addr_next  = ADDR_BUFF;
                    state_next = RD_BYTE;
                end
            end
            RD_BYTE: state_next = W_BYTE;
            W_BYTE: begin
                m_data_next  = RdData;
                m_valid_next = 1'b1;
                m_sof_next   = (cnt_reg == 7'd0);
                m_eof_next   = (cnt_reg == len_reg - 7'd1);
                state_next   = HOLD;
            end
            HOLD: begin
                if (m_valid_reg && M_Ready) begin
                    cnt_next     = cnt_reg + 7'd1;
                    m_valid_next = 1'b0;
                    m_sof_next   = 1'b0;
                    m_eof_next   = 1'b0;
                    if (m_eof_reg) begin
                        frm_done_next = 1'b1;
                        frm_err_next  = err_reg;
                        state_next    = DONE;
                    end else begin
                        rd_en_next = 1'b1;
                        addr_next  = ADDR_BUFF;
                        state_next = RD_BYTE;
                    end
                end
            end
            DROP: begin
                frm_done_next = 1'b1;
                frm_err_next  = err_reg;
                state_next    = DONE;
            end
            DONE: state_next = WAIT_CLR;
            WAIT_CLR: begin
                // A ready still high from the frame just handled must not be re-read.
                if (!Rx_Ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = RESET_STATE;
        endcase

        // A host drop overrides whatever the state chose and is not reported as an error.
        if (host_drop) begin
            err_next   = 4'd0;
            enter_drop = 1'b1;
        end

        if (enter_drop) begin
            state_next   = DROP;
            rd_en_next   = 1'b0;
            wr_en_next   = 1'b1;
            addr_next    = ADDR_SC;
            wr_data_next = DROP_CMD;
            m_valid_next = 1'b0;
            m_sof_next   = 1'b0;
            m_eof_next   = 1'b0;
        end
    end

    assign Address     = addr_reg;
    assign ReadEnable  = rd_en_reg;
    assign WriteEnable = wr_en_reg;
    assign WrData      = wr_data_reg;
    assign M_Data      = m_data_reg;
    assign M_Valid     = m_valid_reg;
    assign M_Sof       = m_sof_reg;
    assign M_Eof       = m_eof_reg;
    assign Frm_Done    = frm_done_reg;
    assign Frm_Err     = frm_err_reg;

endmodule

// File: tb/tb_hdlc_rx_reader.sv
// Randomized scoreboard bench for hdlc_rx_reader with a behavioural HDLC receiver model.
`timescale 1ns/1ps
module tb_hdlc_rx_reader;

    localparam int MAX_LEN = 126;
`ifdef HDLC_RX_READER_FCS_EN
    localparam logic [7:0] DROP_CMD = 8'h22;
    localparam bit         FCS      = 1'b1;
`else
    localparam logic [7:0] DROP_CMD = 8'h02;
    localparam bit         FCS      = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx_Ready = 1'b0;
    logic       M_Ready = 1'b0;
    logic       Drop_Req = 1'b0;
    logic [2:0] Address;
    logic       ReadEnable, WriteEnable;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic [7:0] M_Data;
    logic       M_Valid, M_Sof, M_Eof, Frm_Done;
    logic [3:0] Frm_Err;

    int n_vec = 0;
    int n_err = 0;

    // Expected traffic: bus ops {we, addr, data}, beats {sof, eof, data}, frame errors.
    logic [11:0] bus_q[$];
    logic [9:0]  beat_q[$];
    logic [3:0]  done_q[$];

    logic [7:0] pay[$];
    logic [7:0] hdlc_buf[$];
    logic [7:0] m_sc = 8'h00;
    logic [7:0] m_len = 8'h00;
    bit         mon_en = 1'b0;

    hdlc_rx_reader #(.MAX_LEN(MAX_LEN)) dut (
        .Clk(Clk), .Rst(Rst), .Rx_Ready(Rx_Ready),
        .Address(Address), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
        .WrData(WrData), .RdData(RdData),
        .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
        .M_Sof(M_Sof), .M_Eof(M_Eof),
        .Frm_Done(Frm_Done), .Frm_Err(Frm_Err), .Drop_Req(Drop_Req)
    );

    always #5 Clk = ~Clk;

    // Receiver register file: read data appears the cycle after the strobe.
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            RdData <= 8'h00;
        end else if (ReadEnable) begin
            case (Address)
                3'd2: RdData <= m_sc;
                3'd4: RdData <= m_len;
                3'd3: begin
                    if (hdlc_buf.size() > 0) RdData <= hdlc_buf.pop_front();
                    else                     RdData <= 8'h00;
                end
                default: RdData <= 8'h00;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    logic       p_valid = 0, p_ready = 0, p_done = 0, p_re = 0, p_we = 0;
    logic [9:0] p_beat = 0;
    logic [11:0] mon_op;
    logic [9:0]  mon_beat;

    always @(negedge Clk) begin
        #1;
        if (!Rst || !mon_en) begin
            p_valid = 0; p_ready = 0; p_done = 0; p_re = 0; p_we = 0;
        end else begin
            if (ReadEnable || WriteEnable) begin
                check("strobe_excl", 32'(ReadEnable & WriteEnable), 0);
                check("strobe_one_cycle", 32'((ReadEnable & p_re) | (WriteEnable & p_we)), 0);
                mon_op = {WriteEnable, Address, WriteEnable ? WrData : 8'h00};
                if (bus_q.size() == 0) unexpected("bus_extra", 32'(mon_op));
                else                   check("bus_op", 32'(mon_op), 32'(bus_q.pop_front()));
            end
            mon_beat = {M_Sof, M_Eof, M_Data};
            if (p_valid && !p_ready) begin
                check("valid_held", 32'(M_Valid), 1);
                if (M_Valid) check("beat_stable", 32'(mon_beat), 32'(p_beat));
            end
            if (M_Valid && M_Ready) begin
                if (beat_q.size() == 0) unexpected("beat_extra", 32'(mon_beat));
                else                    check("beat", 32'(mon_beat), 32'(beat_q.pop_front()));
            end
            if (Frm_Done) begin
                check("done_one_cycle", 32'(p_done), 0);
                if (done_q.size() == 0) unexpected("done_extra", 32'(Frm_Err));
                else                    check("frm_err", 32'(Frm_Err), 32'(done_q.pop_front()));
            end
            p_valid = M_Valid; p_ready = M_Ready; p_done = Frm_Done;
            p_re = ReadEnable; p_we = WriteEnable; p_beat = mon_beat;
        end
    end

    // Derives the whole expected frame response from the register contents, then drives it.
    task automatic run_frame(input string tag, input logic [7:0] sc, input int len,
                             input int drop_after, input int stall_idx, input int stall_len,
                             input bit rand_ready, input bit chk_lat);
        logic [2:0] e;
        bit  le, drop_sent, seen;
        int  acc, stall, cyc, lat;
        e  = sc[4:2];
        le = (len == 0) || (len > MAX_LEN);
        while (pay.size() < len) pay.push_back(8'($urandom));
        m_sc = sc;
        m_len = 8'(len);
        hdlc_buf = pay;
        bus_q.push_back({1'b0, 3'd2, 8'h00});
        bus_q.push_back({1'b0, 3'd4, 8'h00});
        if (le || e != 3'd0) begin
            bus_q.push_back({1'b1, 3'd2, DROP_CMD});
            done_q.push_back({le, e});
        end else if (drop_after >= 0) begin
            for (int i = 0; i < drop_after; i++) beat_q.push_back({i == 0, 1'b0, pay[i]});
            for (int i = 0; i <= drop_after; i++) bus_q.push_back({1'b0, 3'd3, 8'h00});
            bus_q.push_back({1'b1, 3'd2, DROP_CMD});
            done_q.push_back(4'd0);
        end else begin
            for (int i = 0; i < len; i++) begin
                beat_q.push_back({i == 0, i == len - 1, pay[i]});
                bus_q.push_back({1'b0, 3'd3, 8'h00});
            end
            done_q.push_back(4'd0);
        end

        Rx_Ready = 1'b1;
        acc = 0; stall = 0; cyc = 0; lat = -1; drop_sent = 0; seen = 0;
        while (!seen && cyc < 4000) begin
            if (drop_after >= 0 && acc == drop_after && !drop_sent) begin
                Drop_Req = 1'b1;
                M_Ready = 1'b0;
                drop_sent = 1'b1;
            end else begin
                Drop_Req = 1'b0;
                if (stall_idx == acc && M_Valid && stall < stall_len) begin
                    M_Ready = 1'b0;
                    stall++;
                end else if (rand_ready) begin
                    M_Ready = ($urandom_range(0, 3) != 0);
                end else begin
                    M_Ready = 1'b1;
                end
                if (M_Valid && M_Ready) acc++;
            end
            @(negedge Clk);
            cyc++;
            if (lat < 0 && M_Valid) lat = cyc;
            if (Frm_Done) seen = 1'b1;
        end
        Drop_Req = 1'b0;
        M_Ready = 1'b1;
        if (!seen) unexpected("done_timeout", 32'(cyc));
        repeat (6) @(negedge Clk);
        Rx_Ready = 1'b0;
        repeat (3) @(negedge Clk);
        check("bus_left", 32'(bus_q.size()), 0);
        check("beat_left", 32'(beat_q.size()), 0);
        check("done_left", 32'(done_q.size()), 0);
        // Edge seeing Rx_Ready in IDLE plus six cycles, observed on the following falling edge.
        if (chk_lat) check("latency", 32'(lat), 7);
        $display("frame %-12s sc=%02h len=%0d drop_after=%0d accepted=%0d cycles=%0d",
                 tag, sc, len, drop_after, acc, cyc);
        pay.delete();
        bus_q.delete(); beat_q.delete(); done_q.delete();
    endtask

    task automatic reset_mid_frame();
        int cyc;
        mon_en = 1'b0;
        pay.delete();
        repeat (10) pay.push_back(8'($urandom_range(1, 255)));
        m_sc = 8'h01;
        m_len = 8'd10;
        hdlc_buf = pay;
        M_Ready = 1'b0;
        Rx_Ready = 1'b1;
        cyc = 0;
        while (!M_Valid && cyc < 50) begin
            @(negedge Clk);
            cyc++;
        end
        check("hold_reached", 32'(M_Valid), 1);
        #2 Rst = 1'b0;
        #1;
        check("rst_mid_bus", 32'({Address, ReadEnable, WriteEnable, WrData}), 0);
        check("rst_mid_stream", 32'({M_Data, M_Valid, M_Sof, M_Eof, Frm_Done, Frm_Err}), 0);
        Rx_Ready = 1'b0;
        bus_q.delete(); beat_q.delete(); done_q.delete(); hdlc_buf.delete(); pay.delete();
        if (FCS) bus_q.push_back({1'b1, 3'd2, 8'h20});
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        mon_en = 1'b1;
        M_Ready = 1'b1;
        repeat (4) @(negedge Clk);
        check("post_reset_init", 32'(bus_q.size()), 0);
        $display("frame %-12s reset asserted in HOLD after %0d cycles", "reset_hold", cyc);
    endtask

    initial begin
        int len, da, r;
        logic [7:0] sc;
        Rst = 1'b0;
        #1;
        check("reset_bus", 32'({Address, ReadEnable, WriteEnable, WrData}), 0);
        check("reset_stream", 32'({M_Data, M_Valid, M_Sof, M_Eof, Frm_Done, Frm_Err}), 0);
        if (FCS) bus_q.push_back({1'b1, 3'd2, 8'h20});
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge Clk);
        check("init_write", 32'(bus_q.size()), 0);

        pay = '{8'hA5, 8'h01, 8'hFF};
        run_frame("good3", 8'h01, 3, -1, -1, 0, 1'b0, 1'b1);
        pay = '{8'hA5, 8'h01, 8'hFF};
        run_frame("backpressure", 8'h01, 3, -1, 1, 5, 1'b0, 1'b0);
        run_frame("abort", 8'h09, 3, -1, -1, 0, 1'b0, 1'b0);
        run_frame("len0", 8'h01, 0, -1, -1, 0, 1'b0, 1'b0);
        run_frame("len127", 8'h01, 127, -1, -1, 0, 1'b0, 1'b0);
        run_frame("host_drop", 8'h01, 10, 1, -1, 0, 1'b0, 1'b0);
        run_frame("max_len", 8'h21, MAX_LEN, -1, -1, 0, 1'b1, 1'b0);
        reset_mid_frame();
        run_frame("after_reset", 8'h01, 5, -1, -1, 0, 1'b1, 1'b1);

        for (int k = 0; k < 16; k++) begin
            r   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 24));
            sc  = 8'h01 | (($urandom_range(0, 1) != 0) ? 8'h20 : 8'h00);
            da  = -1;
            if (r == 0)                  sc |= 8'h04;
            else if (r == 1)             sc |= 8'h10;
            else if (r == 2)             len = int'($urandom_range(127, 255));
            else if (r == 3 && len >= 2) da = int'($urandom_range(1, len - 1));
            run_frame("random", sc, len, da, -1, 0, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
